// File: rtl/serial_word_bridge.sv
// UART endpoint with multi-byte word framing on valid/ready ports.
// RX: glitch reject, frame/overrun/timeout flags. TX: back-to-back bytes.
module serial_word_bridge #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int I_BYTES      = 1,
    parameter int O_BYTES      = 1,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_txd_in,
    output logic                 uart_rxd_out,
    output logic [8*O_BYTES-1:0] o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    input  logic [8*I_BYTES-1:0] i_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_timeout
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int TW  = $clog2(DIV + 1);
    localparam int OBW = $clog2(O_BYTES + 1);
    localparam int IBW = $clog2(I_BYTES + 1);
    localparam int TMO = TIMEOUT_BITS * DIV;
    localparam int TOW = $clog2(TMO + 1);

    localparam logic [TW-1:0]  BIT_END  = TW'(DIV - 1);
    localparam logic [TW-1:0]  HALF_END = TW'(DIV / 2 - 1);
    localparam logic [TOW-1:0] TMO_END  = TOW'(TMO - 1);
    localparam logic [OBW-1:0] O_LAST   = OBW'(O_BYTES - 1);
    localparam logic [IBW-1:0] I_LAST   = IBW'(I_BYTES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_INIT,
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    logic rx_meta;
    logic rx_sync;

    rx_state_t rx_state;
    rx_state_t rx_next;

    logic [TW-1:0] rx_timer;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          rx_tick;
    logic          rx_bit_en;
    logic          rx_byte_ok;
    logic          rx_byte_bad;

    logic [OBW-1:0]       asm_cnt;
    logic [8*O_BYTES-1:0] asm_word;
    logic [8*O_BYTES-1:0] asm_next;
    logic [TOW-1:0]       idle_cnt;
    logic                 idle_run;
    logic                 tmo_hit;
    logic                 word_done;
    logic                 out_free;

    tx_state_t tx_state;
    tx_state_t tx_next;

    logic [TW-1:0]        tx_timer;
    logic [3:0]           tx_bits;
    logic [IBW-1:0]       tx_bytes;
    logic [8:0]           tx_frame;
    logic [8*I_BYTES-1:0] tx_word;
    logic                 tx_line;
    logic                 tx_accept;
    logic                 tx_tick;
    logic                 tx_frame_end;
    logic                 tx_last;

    // Line idles high, so the synchroniser resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_txd_in;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bits == 4'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_tick = 1'b0;
        unique case (rx_state)
            RX_START: rx_tick = (rx_timer == HALF_END);
            RX_DATA:  rx_tick = (rx_timer == BIT_END);
            RX_STOP:  rx_tick = (rx_timer == BIT_END);
            default:  rx_tick = 1'b0;
        endcase
        rx_bit_en   = (rx_state == RX_DATA) && rx_tick;
        rx_byte_ok  = (rx_state == RX_STOP) && rx_tick && rx_sync;
        rx_byte_bad = (rx_state == RX_STOP) && rx_tick && !rx_sync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_timer <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_timer <= '0;
            else                                rx_timer <= rx_timer + 1'b1;
            if (rx_state != RX_DATA) rx_bits <= '0;
            else if (rx_bit_en)      rx_bits <= rx_bits + 1'b1;
            if (rx_bit_en) rx_shift <= {rx_sync, rx_shift[7:1]};
        end
    end

    // Arrival order k lands in byte lane k.
    always_comb begin
        asm_next = asm_word;
        for (int k = 0; k < O_BYTES; k++) begin
            if (k == int'(asm_cnt)) asm_next[8*k +: 8] = rx_shift;
        end
        idle_run  = (rx_state == RX_IDLE) && (asm_cnt != '0);
        tmo_hit   = idle_run && (idle_cnt == TMO_END);
        word_done = rx_byte_ok && (asm_cnt == O_LAST);
        out_free  = !o_valid || o_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_cnt      <= '0;
            asm_word     <= '0;
            idle_cnt     <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_timeout   <= 1'b0;
        end else begin
            rx_frame_err <= rx_byte_bad;
            rx_overrun   <= word_done && !out_free;
            rx_timeout   <= tmo_hit;
            if (idle_run && !tmo_hit) idle_cnt <= idle_cnt + 1'b1;
            else                      idle_cnt <= '0;
            if (rx_byte_bad || tmo_hit || word_done) begin
                asm_cnt  <= '0;
                asm_word <= '0;
            end else if (rx_byte_ok) begin
                asm_cnt  <= asm_cnt + 1'b1;
                asm_word <= asm_next;
            end
            // A held word wins over a new one unless it is taken this clk.
            if (word_done && out_free) begin
                o_data  <= asm_next;
                o_valid <= 1'b1;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_INIT;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_INIT: tx_next = TX_IDLE;
            TX_IDLE: if (tx_accept) tx_next = TX_SEND;
            TX_SEND: if (tx_last) tx_next = TX_IDLE;
            default: tx_next = TX_INIT;
        endcase
    end

    always_comb begin
        i_ready      = (tx_state == TX_IDLE);
        tx_accept    = i_ready && i_valid;
        tx_tick      = (tx_state == TX_SEND) && (tx_timer == BIT_END);
        tx_frame_end = tx_tick && (tx_bits == 4'd9);
        tx_last      = tx_frame_end && (tx_bytes == I_LAST);
    end

    // tx_frame holds the bits still to go after the one on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_line  <= 1'b1;
            tx_timer <= '0;
            tx_bits  <= '0;
            tx_bytes <= '0;
            tx_frame <= '1;
            tx_word  <= '0;
        end else if (tx_accept) begin
            tx_line  <= 1'b0;
            tx_timer <= '0;
            tx_bits  <= '0;
            tx_bytes <= '0;
            tx_frame <= {1'b1, i_data[7:0]};
            tx_word  <= i_data >> 8;
        end else if (tx_tick) begin
            tx_timer <= '0;
            if (tx_last) begin
                tx_line <= 1'b1;
            end else if (tx_frame_end) begin
                tx_line  <= 1'b0;
                tx_bits  <= '0;
                tx_bytes <= tx_bytes + 1'b1;
                tx_frame <= {1'b1, tx_word[7:0]};
                tx_word  <= tx_word >> 8;
            end else begin
                tx_line  <= tx_frame[0];
                tx_bits  <= tx_bits + 1'b1;
                tx_frame <= {1'b0, tx_frame[8:1]};
            end
        end else if (tx_state == TX_SEND) begin
            tx_timer <= tx_timer + 1'b1;
        end
    end

    assign uart_rxd_out = tx_line;

endmodule
